rom_port_arbiter: RTL
=====================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 18, ROM instruction width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, consecutive CPU-won cycles before debug is forced through.
REQ-004 Port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: RST  in  1  synchronous, active-high reset.
REQ-006 Port: CPU_REQ  in  1  CPU fetch request.
REQ-007 Port: CPU_ADDR  in  ADDR_W  CPU fetch address (PC).
REQ-008 Port: CPU_GNT  out  1  CPU request accepted this cycle (combinational).
REQ-009 Port: CPU_VALID  out  1  CPU data returned this cycle.
REQ-010 Port: CPU_IR  out  DATA_W  CPU instruction word, held between returns.
REQ-011 Port: DBG_REQ  in  1  debug/readback request.
REQ-012 Port: DBG_ADDR  in  ADDR_W  debug read address.
REQ-013 Port: DBG_GNT  out  1  debug request accepted this cycle (combinational).
REQ-014 Port: DBG_VALID  out  1  debug data returned this cycle.
REQ-015 Port: DBG_DATA  out  DATA_W  debug read word, held between returns.
REQ-016 Port: ROM_ADDR  out  ADDR_W  address to the synchronous program ROM.
REQ-017 Port: ROM_IR  in  DATA_W  ROM read data, valid one cycle after address.

Function
REQ-018 At most one of CPU_GNT, DBG_GNT SHALL be high in any cycle.
REQ-019 State NORMAL: CPU_REQ high -> CPU_GNT; else DBG_REQ high -> DBG_GNT.
REQ-020 State FORCE: DBG_REQ high -> DBG_GNT and CPU_GNT low regardless of CPU_REQ; DBG_REQ low -> behave as NORMAL.
REQ-021 Counter starve_cnt SHALL increment each cycle CPU_GNT and DBG_REQ are both high, saturating at STARVE_LIMIT.
REQ-022 starve_cnt SHALL clear on any DBG_GNT or any cycle DBG_REQ is low.
REQ-023 Transition NORMAL->FORCE SHALL occur on the edge where starve_cnt reaches STARVE_LIMIT; FORCE->NORMAL on the edge after a DBG_GNT or when DBG_REQ is low.
REQ-024 ROM_ADDR SHALL equal the granted requester's address; with no grant, ROM_ADDR SHALL hold the last granted address.
REQ-025 CPU_VALID SHALL be CPU_GNT delayed one cycle; DBG_VALID likewise from DBG_GNT (latency exactly 1).
REQ-026 CPU_IR SHALL equal ROM_IR while CPU_VALID is high and otherwise hold the word captured at the last CPU_VALID; DBG_DATA identically for DBG_VALID.
REQ-027 A requester not granted SHALL keep REQ and ADDR stable; the block SHALL not latch ungranted requests.
REQ-028 Back-to-back grants to either side SHALL be supported every cycle (full throughput).
REQ-029 STARVE_LIMIT=0 SHALL mean debug always has priority when requesting.

Reset
REQ-030 While RST is high: CPU_VALID, DBG_VALID, CPU_IR, DBG_DATA, ROM_ADDR, starve_cnt = 0, state = NORMAL; grants still follow REQ-019 from reset state.
REQ-031 A grant issued in the cycle RST asserts SHALL produce no VALID in the following cycle.

Structure
REQ-032 ADDR_W/DATA_W defaults and the state enum (NORMAL, FORCE) SHALL live in shared package rat_rom_pkg.
REQ-033 The valid-delay plus hold register SHALL be sub-module rom_rd_hold, instantiated once per requester.

Verification
REQ-034 CPU only, CPU_ADDR 0x000..0x003 consecutive cycles -> CPU_GNT every cycle, CPU_IR = rom[0..3] one cycle later each.
REQ-035 Debug only, DBG_ADDR=0x3FF -> DBG_VALID next cycle, DBG_DATA=rom[0x3FF] held after DBG_REQ drops.
REQ-036 CPU and DBG_REQ continuously high, STARVE_LIMIT=4 -> 4 CPU grants, 1 DBG grant, repeating; CPU_IR unchanged during the debug cycle.
REQ-037 DBG_REQ drops at starve_cnt=3 -> counter clears, state stays NORMAL, no forced slot.
REQ-038 RST asserted the cycle after CPU_GNT at 0x010 -> CPU_VALID stays 0, CPU_IR=0, state NORMAL.

Source files
------------

// File: rtl/rat_rom_pkg.sv
// Shared definitions for the program-ROM port arbiter: default widths,
// the arbitration state type and a helper that sizes the starvation counter.
package rat_rom_pkg;

    localparam int ROM_ADDR_W       = 10;
    localparam int ROM_DATA_W       = 18;
    localparam int STARVE_LIMIT_DEF = 4;

    // NORMAL: CPU has priority. FORCE: a waiting debug request wins.
    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

    // Width needed to count 0..limit. A limit of 0 still needs a 1-bit register.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/rom_rd_hold.sv
// Read-return stage for one ROM requester.
// The grant is delayed by one cycle to match the synchronous ROM latency.
// The returned word is passed straight through in the valid cycle and held
// afterwards.
module rom_rd_hold
    import rat_rom_pkg::*;
#(
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_gnt,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_hold;

    // Delay the grant by one cycle and capture the word returned in each valid cycle.
    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values, whatever the statement order.
        if (i_rst) begin
            r_valid <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_valid <= i_gnt;
            if (r_valid) begin
                r_hold <= i_rom_data;
            end
        end
    end

    // Reset blanks the outputs at once. This also suppresses a return whose
    // grant was issued in the cycle just before reset.
    assign o_valid = r_valid && !i_rst;
    assign o_data  = i_rst ? '0 : (r_valid ? i_rom_data : r_hold);

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates one synchronous program ROM between the CPU fetch port and a
// debug/readback port.
// The CPU normally wins. After STARVE_LIMIT consecutive cycles in which a
// debug request lost to the CPU, the next cycle goes to debug.
module rom_port_arbiter
    import rat_rom_pkg::*;
#(
    parameter int ADDR_W       = ROM_ADDR_W,
    parameter int DATA_W       = ROM_DATA_W,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_REQ,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    output logic              CPU_GNT,
    output logic              CPU_VALID,
    output logic [DATA_W-1:0] CPU_IR,
    input  logic              DBG_REQ,
    input  logic [ADDR_W-1:0] DBG_ADDR,
    output logic              DBG_GNT,
    output logic              DBG_VALID,
    output logic [DATA_W-1:0] DBG_DATA,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [DATA_W-1:0] ROM_IR
);

    localparam int                CNT_W   = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [ADDR_W-1:0] r_last_addr;

    logic              w_force_dbg;
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_enter_force;
    logic [ADDR_W-1:0] w_rom_addr;

    // Grant decision. Debug is pushed ahead of the CPU only in FORCE, or
    // always when the limit is 0. During reset the machine behaves as NORMAL.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        w_force_dbg = 1'b0;
        if (!RST && DBG_REQ) begin
            if (STARVE_LIMIT == 0) begin
                w_force_dbg = 1'b1;
            end else if (r_state == FORCE) begin
                w_force_dbg = 1'b1;
            end
        end
        w_cpu_gnt = CPU_REQ && !w_force_dbg;
        w_dbg_gnt = DBG_REQ && !w_cpu_gnt;
    end

    // Starvation count: grows while debug waits behind the CPU, saturates at
    // the limit, and clears once debug is served or stops asking.
    always_comb begin
        w_cnt_next = r_starve_cnt;
        if (w_dbg_gnt || !DBG_REQ) begin
            w_cnt_next = '0;
        end else if (w_cpu_gnt && (r_starve_cnt != LIMIT_C)) begin
            w_cnt_next = r_starve_cnt + 1'b1;
        end
        w_enter_force = (STARVE_LIMIT != 0) && w_cpu_gnt && DBG_REQ
                        && (w_cnt_next == LIMIT_C);
    end

    // Arbitration state, starvation counter and last-granted address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= NORMAL;
            r_starve_cnt <= '0;
            r_last_addr  <= '0;
        end else begin
            r_starve_cnt <= w_cnt_next;
            case (r_state)
                NORMAL: if (w_enter_force)             r_state <= FORCE;
                FORCE:  if (w_dbg_gnt || !DBG_REQ)     r_state <= NORMAL;
            endcase
            if (w_cpu_gnt) begin
                r_last_addr <= CPU_ADDR;
            end else if (w_dbg_gnt) begin
                r_last_addr <= DBG_ADDR;
            end
        end
    end

    // Drive the ROM with the winner's address. With no grant, hold the last
    // granted address to avoid needless ROM address toggling.
    always_comb begin
        w_rom_addr = r_last_addr;
        if (RST) begin
            w_rom_addr = '0;
        end else if (w_cpu_gnt) begin
            w_rom_addr = CPU_ADDR;
        end else if (w_dbg_gnt) begin
            w_rom_addr = DBG_ADDR;
        end
    end

    assign CPU_GNT  = w_cpu_gnt;
    assign DBG_GNT  = w_dbg_gnt;
    assign ROM_ADDR = w_rom_addr;

    rom_rd_hold #(
        .DATA_W (DATA_W)
    ) u_cpu_hold (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_gnt      (w_cpu_gnt),
        .i_rom_data (ROM_IR),
        .o_valid    (CPU_VALID),
        .o_data     (CPU_IR)
    );

    rom_rd_hold #(
        .DATA_W (DATA_W)
    ) u_dbg_hold (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_gnt      (w_dbg_gnt),
        .i_rom_data (ROM_IR),
        .o_valid    (DBG_VALID),
        .o_data     (DBG_DATA)
    );

endmodule
